// File: rtl/memaccess_seq_pkg.sv
// rtl/memaccess_seq_pkg.sv - shared types for the memory-access request sequencer
package memaccess_seq_pkg;

    // Request opcode. Bit 0 selects the indirect (pointer) form, bit 1 selects store.
    typedef enum logic [1:0] {
        OP_LOAD      = 2'd0,
        OP_LOAD_IND  = 2'd1,
        OP_STORE     = 2'd2,
        OP_STORE_IND = 2'd3
    } mem_op_t;

    // Bus state seen by the memaccess_in agent.
    typedef enum logic [1:0] {
        MS_READ_IND = 2'b00,
        MS_READ     = 2'b01,
        MS_WRITE    = 2'b10,
        MS_IDLE     = 2'b11
    } mem_state_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_IND,
        S_ACC,
        S_RESP
    } seq_state_t;

    function automatic logic op_is_indirect(input mem_op_t op);
        return op[0];
    endfunction

    function automatic logic op_is_store(input mem_op_t op);
        return op[1];
    endfunction

endpackage

// File: rtl/memaccess_seq.sv
// rtl/memaccess_seq.sv - sequences one load/store request onto the memaccess_in bus
//
// Ports:
//   clock, reset           : rising-edge clock, synchronous active-low reset
//   req_valid/ready/op/addr/data : request from execute (one outstanding at most)
//   MControl, MAddr, MData, mem_state : registered memaccess_in bus outputs
//   DMem_out               : read data, valid in the READ / READ_IND cycle
//   rsp_valid/ready/data/is_load : completion toward writeback
module memaccess_seq
    import memaccess_seq_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    output logic              MControl,
    output logic [ADDR_W-1:0] MAddr,
    output logic [DATA_W-1:0] MData,
    output logic [1:0]        mem_state,
    input  logic [DATA_W-1:0] DMem_out,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_is_load
);

    seq_state_t        state_q, state_d;
    mem_op_t           op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [ADDR_W-1:0] maddr_q, maddr_d;
    logic [DATA_W-1:0] mdata_q, mdata_d;
    logic              mcontrol_q, mcontrol_d;
    mem_state_t        mem_state_q, mem_state_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_is_load_q, rsp_is_load_d;
    logic              accept;
    mem_op_t           req_op_e;

    assign req_op_e = mem_op_t'(req_op);

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        addr_d        = addr_q;
        data_d        = data_q;
        maddr_d       = maddr_q;
        mdata_d       = mdata_q;
        mcontrol_d    = 1'b0;
        mem_state_d   = MS_IDLE;
        rsp_data_d    = rsp_data_q;
        rsp_is_load_d = rsp_is_load_q;
        req_ready     = 1'b0;
        accept        = 1'b0;

        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                accept    = req_valid;
            end
            S_IND: begin
                // Second phase: downstream substitutes the fetched pointer for MAddr.
                state_d     = S_ACC;
                mcontrol_d  = 1'b1;
                maddr_d     = addr_q;
                mem_state_d = op_is_store(op_q) ? MS_WRITE : MS_READ;
                if (op_is_store(op_q)) begin
                    mdata_d = data_q;
                end
            end
            S_ACC: begin
                state_d       = S_RESP;
                rsp_is_load_d = !op_is_store(op_q);
                rsp_data_d    = op_is_store(op_q) ? '0 : DMem_out;
            end
            S_RESP: begin
                // Completing response frees the slot, so a new request may enter on the same edge.
                req_ready = rsp_ready;
                if (rsp_ready) begin
                    state_d = S_IDLE;
                    accept  = req_valid;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (accept) begin
            op_d    = req_op_e;
            addr_d  = req_addr;
            data_d  = req_data;
            maddr_d = req_addr;
            if (op_is_indirect(req_op_e)) begin
                state_d     = S_IND;
                mem_state_d = MS_READ_IND;
            end else begin
                state_d     = S_ACC;
                mem_state_d = op_is_store(req_op_e) ? MS_WRITE : MS_READ;
                if (op_is_store(req_op_e)) begin
                    mdata_d = req_data;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            op_q          <= OP_LOAD;
            addr_q        <= '0;
            data_q        <= '0;
            maddr_q       <= '0;
            mdata_q       <= '0;
            mcontrol_q    <= 1'b0;
            mem_state_q   <= MS_IDLE;
            rsp_data_q    <= '0;
            rsp_is_load_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            addr_q        <= addr_d;
            data_q        <= data_d;
            maddr_q       <= maddr_d;
            mdata_q       <= mdata_d;
            mcontrol_q    <= mcontrol_d;
            mem_state_q   <= mem_state_d;
            rsp_data_q    <= rsp_data_d;
            rsp_is_load_q <= rsp_is_load_d;
        end
    end

    assign MControl    = mcontrol_q;
    assign MAddr       = maddr_q;
    assign MData       = mdata_q;
    assign mem_state   = mem_state_q;
    assign rsp_valid   = (state_q == S_RESP);
    assign rsp_data    = rsp_data_q;
    assign rsp_is_load = rsp_is_load_q;

endmodule

// File: tb/tb_memaccess_seq.sv
// tb/tb_memaccess_seq.sv - randomized self-checking bench for memaccess_seq
module tb_memaccess_seq;

    localparam logic [1:0] LD = 2'd0, LDI = 2'd1, ST = 2'd2, STI = 2'd3;
    localparam logic [1:0] B_RIND = 2'b00, B_READ = 2'b01, B_WRITE = 2'b10, B_IDLE = 2'b11;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'd0;
    logic [15:0] req_addr = '0;
    logic [15:0] req_data = '0;
    logic        MControl;
    logic [15:0] MAddr;
    logic [15:0] MData;
    logic [1:0]  mem_state;
    logic [15:0] DMem_out;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_data;
    logic        rsp_is_load;

    int errors = 0;
    int checks = 0;

    logic        force_en = 1'b0;
    logic [15:0] force_val = '0;

    memaccess_seq #(.ADDR_W(16), .DATA_W(16)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_data(req_data),
        .MControl(MControl), .MAddr(MAddr), .MData(MData), .mem_state(mem_state),
        .DMem_out(DMem_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_is_load(rsp_is_load)
    );

    always #5 clock = ~clock;

    // Memory contents model: every address holds a scrambled function of itself.
    function automatic logic [15:0] mem_f(input logic [15:0] a);
        logic [15:0] t;
        t = a * 16'h9E37;
        return t ^ 16'h5A5A;
    endfunction

    // Behaves as the downstream memory stage: pointer phase reads mem[MAddr],
    // second indirect phase reads mem[mem[MAddr]]; non-read cycles return junk.
    always_comb begin
        DMem_out = 16'hDEAD;
        if (force_en && mem_state == B_READ) begin
            DMem_out = force_val;
        end else if (mem_state == B_READ_IND_C()) begin
            DMem_out = mem_f(MAddr);
        end else if (mem_state == B_READ) begin
            DMem_out = MControl ? mem_f(mem_f(MAddr)) : mem_f(MAddr);
        end
    end

    function automatic logic [1:0] B_READ_IND_C();
        return B_RIND;
    endfunction

    function automatic logic [15:0] expected_rsp(input logic [1:0] op, input logic [15:0] a);
        case (op)
            LD:      return mem_f(a);
            LDI:     return mem_f(mem_f(a));
            default: return 16'h0000;
        endcase
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Drives one request and follows its bus timeline, holding rsp_ready low for `hold` response cycles.
    task automatic do_req(input logic [1:0] op, input logic [15:0] a, input logic [15:0] d,
                          input int hold, input logic [15:0] exp_data);
        logic ind, st;
        ind = op[0];
        st  = op[1];
        req_valid = 1'b1; req_op = op; req_addr = a; req_data = d;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL req_ready_idle: got %b expected 1", req_ready); end
        step();
        req_valid = 1'b0; req_op = 2'($urandom); req_addr = 16'($urandom); req_data = 16'($urandom);
        #1;
        if (ind) begin
            checks++; if (mem_state !== B_RIND) begin errors++; $display("FAIL ind_mem_state: got %b expected 00", mem_state); end
            checks++; if (MAddr !== a) begin errors++; $display("FAIL ind_maddr: got %h expected %h", MAddr, a); end
            checks++; if (MControl !== 1'b0) begin errors++; $display("FAIL ind_mcontrol: got %b expected 0", MControl); end
            checks++; if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL ind_handshake: got ready=%b valid=%b expected 0 0", req_ready, rsp_valid); end
            step();
            #1;
        end
        checks++; if (mem_state !== (st ? B_WRITE : B_READ)) begin errors++; $display("FAIL acc_mem_state: got %b expected %b", mem_state, (st ? B_WRITE : B_READ)); end
        checks++; if (MControl !== ind) begin errors++; $display("FAIL acc_mcontrol: got %b expected %b", MControl, ind); end
        checks++; if (MAddr !== a) begin errors++; $display("FAIL acc_maddr: got %h expected %h", MAddr, a); end
        if (st) begin
            checks++; if (MData !== d) begin errors++; $display("FAIL acc_mdata: got %h expected %h", MData, d); end
        end
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin errors++; $display("FAIL acc_handshake: got valid=%b ready=%b expected 0 0", rsp_valid, req_ready); end
        step();
        #1;
        for (int h = 0; h < hold; h++) begin
            checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL hold_valid: got %b expected 1", rsp_valid); end
            checks++; if (rsp_data !== exp_data) begin errors++; $display("FAIL hold_data: got %h expected %h", rsp_data, exp_data); end
            checks++; if (rsp_is_load !== !st) begin errors++; $display("FAIL hold_is_load: got %b expected %b", rsp_is_load, !st); end
            checks++; if (mem_state !== B_IDLE || req_ready !== 1'b0) begin errors++; $display("FAIL hold_bus: got state=%b ready=%b expected 11 0", mem_state, req_ready); end
            step();
            #1;
        end
        rsp_ready = 1'b1;
        #1;
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL rsp_valid: got %b expected 1", rsp_valid); end
        checks++; if (rsp_data !== exp_data) begin errors++; $display("FAIL rsp_data: got %h expected %h", rsp_data, exp_data); end
        checks++; if (rsp_is_load !== !st) begin errors++; $display("FAIL rsp_is_load: got %b expected %b", rsp_is_load, !st); end
        checks++; if (req_ready !== 1'b1 || mem_state !== B_IDLE) begin errors++; $display("FAIL rsp_bus: got ready=%b state=%b expected 1 11", req_ready, mem_state); end
        step();
        rsp_ready = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b0 || mem_state !== B_IDLE) begin errors++; $display("FAIL after_rsp: got valid=%b state=%b expected 0 11", rsp_valid, mem_state); end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) step();
        #1;
        checks++; if (mem_state !== B_IDLE) begin errors++; $display("FAIL reset_mem_state: got %b expected 11", mem_state); end
        checks++; if (MControl !== 1'b0) begin errors++; $display("FAIL reset_mcontrol: got %b expected 0", MControl); end
        checks++; if (MAddr !== 16'h0 || MData !== 16'h0) begin errors++; $display("FAIL reset_maddr_mdata: got %h %h expected 0 0", MAddr, MData); end
        checks++; if (rsp_valid !== 1'b0 || rsp_data !== 16'h0 || rsp_is_load !== 1'b0) begin errors++; $display("FAIL reset_rsp: got %b %h %b expected 0 0 0", rsp_valid, rsp_data, rsp_is_load); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
        reset = 1'b1;
        step();
    endtask

    task automatic test_load();
        force_en = 1'b1; force_val = 16'hBEEF;
        do_req(LD, 16'h3000, 16'h0000, 0, 16'hBEEF);
        force_en = 1'b0;
    endtask

    task automatic test_store_ind();
        do_req(STI, 16'h4000, 16'h1234, 0, 16'h0000);
    endtask

    task automatic test_backpressure();
        logic [15:0] a;
        a = 16'($urandom);
        do_req(LD, a, 16'h0, 4, expected_rsp(LD, a));
    endtask

    task automatic test_back_to_back();
        logic [15:0] addrs[4];
        logic [15:0] expq[$];
        int acc_cyc[4];
        int idx, resp;
        logic will_acc;
        logic [15:0] e;
        idx = 0; resp = 0;
        for (int i = 0; i < 4; i++) addrs[i] = 16'($urandom);
        rsp_ready = 1'b1; req_op = LD;
        for (int c = 0; c < 40 && resp < 4; c++) begin
            req_valid = (idx < 4);
            req_addr  = addrs[idx < 4 ? idx : 3];
            #1;
            will_acc = req_valid && req_ready;
            if (rsp_valid && rsp_ready) begin
                e = expq.pop_front();
                checks++; if (rsp_data !== e || rsp_is_load !== 1'b1) begin errors++; $display("FAIL b2b_rsp%0d: got %h/%b expected %h/1", resp, rsp_data, rsp_is_load, e); end
                resp++;
            end
            step();
            if (will_acc) begin
                acc_cyc[idx] = c;
                expq.push_back(expected_rsp(LD, addrs[idx]));
                idx++;
            end
        end
        req_valid = 1'b0; rsp_ready = 1'b0;
        checks++; if (resp !== 4) begin errors++; $display("FAIL b2b_count: got %0d expected 4", resp); end
        for (int i = 1; i < 4; i++) begin
            checks++; if (i < idx && acc_cyc[i] - acc_cyc[i-1] !== 2) begin errors++; $display("FAIL b2b_spacing%0d: got %0d expected 2", i, acc_cyc[i] - acc_cyc[i-1]); end
        end
        step();
        #1;
        checks++; if (rsp_valid !== 1'b0 || mem_state !== B_IDLE) begin errors++; $display("FAIL b2b_idle: got %b %b expected 0 11", rsp_valid, mem_state); end
    endtask

    task automatic test_random();
        logic [1:0]  op;
        logic [15:0] a, d;
        for (int i = 0; i < 16; i++) begin
            op = 2'($urandom);
            a  = 16'($urandom);
            d  = 16'($urandom);
            do_req(op, a, d, int'($urandom_range(0, 3)), expected_rsp(op, a));
        end
    endtask

    task automatic test_reset_midop();
        req_valid = 1'b1; req_op = LDI; req_addr = 16'h5555; req_data = 16'h0;
        step();
        req_valid = 1'b0;
        #1;
        checks++; if (mem_state !== B_RIND) begin errors++; $display("FAIL midop_ind: got %b expected 00", mem_state); end
        reset = 1'b0;
        step();
        reset = 1'b1;
        #1;
        checks++; if (mem_state !== B_IDLE || MControl !== 1'b0) begin errors++; $display("FAIL midop_bus: got %b %b expected 11 0", mem_state, MControl); end
        checks++; if (MAddr !== 16'h0 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL midop_state: got %h %b %b expected 0 0 1", MAddr, rsp_valid, req_ready); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL midop_no_rsp: got %b expected 0", rsp_valid); end
        end
        do_req(LD, 16'h0777, 16'h0, 1, expected_rsp(LD, 16'h0777));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_load();
        test_store_ind();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_reset_midop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
